// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register numbers and the hazard shadow entry.
package lc3b_types;

  localparam int unsigned LC3B_REG_WIDTH = 3;
  localparam int unsigned LC3B_NUM_REGS  = 8;

  typedef logic [LC3B_REG_WIDTH-1:0] lc3b_reg;

  typedef struct packed {
    logic    valid;
    lc3b_reg dr;
    logic    load_reg;
    logic    is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '{valid: 1'b0, dr: 3'd0, load_reg: 1'b0, is_load: 1'b0};

  // One-hot decode of a register number into a per-register mask.
  function automatic logic [LC3B_NUM_REGS-1:0] reg_onehot(input lc3b_reg r);
    return LC3B_NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/load_use_hazard_unit_if.sv
// ID-stage hazard bundle between the pipeline (master) and the hazard unit (slave).
interface load_use_hazard_unit_if #(
  parameter int unsigned STALL_CNT_WIDTH = 16
);
  import lc3b_types::*;

  logic                       id_valid;
  lc3b_reg                    id_SR1;
  lc3b_reg                    id_SR2;
  logic                       id_sr1_used;
  logic                       id_sr2_used;
  lc3b_reg                    id_DR;
  logic                       id_load_reg;
  logic                       id_is_load;
  logic                       mem_stall;
  logic                       flush;
  logic                       stat_clear;

  logic                       load_use_stall;
  logic                       stall_id;
  logic                       bubble_ex;
  lc3b_reg                    ex_mem_DR;
  lc3b_reg                    mem_wb_DR;
  logic                       ex_mem_load_reg;
  logic                       mem_wb_load_reg;
  logic [7:0]                 pending_mask;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  modport master (
    output id_valid, id_SR1, id_SR2, id_sr1_used, id_sr2_used, id_DR,
           id_load_reg, id_is_load, mem_stall, flush, stat_clear,
    input  load_use_stall, stall_id, bubble_ex, ex_mem_DR, mem_wb_DR,
           ex_mem_load_reg, mem_wb_load_reg, pending_mask, stall_count
  );

  modport slave (
    input  id_valid, id_SR1, id_SR2, id_sr1_used, id_sr2_used, id_DR,
           id_load_reg, id_is_load, mem_stall, flush, stat_clear,
    output load_use_stall, stall_id, bubble_ex, ex_mem_DR, mem_wb_DR,
           ex_mem_load_reg, mem_wb_load_reg, pending_mask, stall_count
  );

endinterface

// File: rtl/load_use_hazard_unit_hazard_shadow_stage.sv
// One shadow pipeline entry: hold beats bubble, bubble beats load.
module hazard_shadow_stage
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          bubble,
  input  shadow_entry_t entry_i,
  output shadow_entry_t entry_o
);

  shadow_entry_t entry_q;
  shadow_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (hold) begin
      entry_d = entry_q;
    end else if (bubble) begin
      entry_d = SHADOW_BUBBLE;
    end else begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= SHADOW_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection beside ID, with an EX/MEM/WB shadow of destination writes.
module load_use_hazard_unit
  import lc3b_types::*;
#(
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  load_use_hazard_unit_if.slave hz
);

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

  shadow_entry_t ex_q;
  shadow_entry_t mem_q;
  shadow_entry_t wb_q;
  shadow_entry_t id_entry;

  logic load_use_stall_c;
  logic bubble_ex_c;
  logic ex_bubble_c;
  logic unused_wb;

  logic [STALL_CNT_WIDTH-1:0] stall_count_q;
  logic [STALL_CNT_WIDTH-1:0] stall_count_d;
  logic [LC3B_NUM_REGS-1:0]   pending_c;

  // Only a load still in EX cannot be forwarded in time.
  always_comb begin
    load_use_stall_c = hz.id_valid & ~hz.flush &
                       ex_q.valid & ex_q.load_reg & ex_q.is_load &
                       ((hz.id_sr1_used & (hz.id_SR1 == ex_q.dr)) |
                        (hz.id_sr2_used & (hz.id_SR2 == ex_q.dr)));
    bubble_ex_c      = load_use_stall_c & ~hz.mem_stall;
    ex_bubble_c      = load_use_stall_c | hz.flush | ~hz.id_valid;
    id_entry         = '{valid: 1'b1, dr: hz.id_DR, load_reg: hz.id_load_reg,
                         is_load: hz.id_is_load};
  end

  hazard_shadow_stage u_ex (
    .clk     (clk),
    .reset   (reset),
    .hold    (hz.mem_stall),
    .bubble  (ex_bubble_c),
    .entry_i (id_entry),
    .entry_o (ex_q)
  );

  hazard_shadow_stage u_mem (
    .clk     (clk),
    .reset   (reset),
    .hold    (hz.mem_stall),
    .bubble  (1'b0),
    .entry_i (ex_q),
    .entry_o (mem_q)
  );

  hazard_shadow_stage u_wb (
    .clk     (clk),
    .reset   (reset),
    .hold    (hz.mem_stall),
    .bubble  (1'b0),
    .entry_i (mem_q),
    .entry_o (wb_q)
  );

  assign unused_wb = wb_q.is_load;

  always_comb begin
    pending_c = '0;
    if (ex_q.valid & ex_q.load_reg) begin
      pending_c = pending_c | reg_onehot(ex_q.dr);
    end
    if (mem_q.valid & mem_q.load_reg) begin
      pending_c = pending_c | reg_onehot(mem_q.dr);
    end
    if (wb_q.valid & wb_q.load_reg) begin
      pending_c = pending_c | reg_onehot(wb_q.dr);
    end
  end

  // Saturating bubble counter; clear wins over increment.
  always_comb begin
    stall_count_d = stall_count_q;
    if (hz.stat_clear) begin
      stall_count_d = '0;
    end else if (bubble_ex_c && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.load_use_stall  = load_use_stall_c;
  assign hz.stall_id        = load_use_stall_c | hz.mem_stall;
  assign hz.bubble_ex       = bubble_ex_c;
  assign hz.ex_mem_DR       = mem_q.dr;
  assign hz.ex_mem_load_reg = mem_q.valid & mem_q.load_reg;
  assign hz.mem_wb_DR       = wb_q.dr;
  assign hz.mem_wb_load_reg = wb_q.valid & wb_q.load_reg;
  assign hz.pending_mask    = pending_c;
  assign hz.stall_count     = stall_count_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit with hand-computed expectations.
module tb_load_use_hazard_unit;
  import lc3b_types::*;

  localparam int unsigned CW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  load_use_hazard_unit_if #(.STALL_CNT_WIDTH(CW)) hz ();

  load_use_hazard_unit #(.STALL_CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] sr1, input logic u1,
                        input logic [2:0] sr2, input logic u2, input logic [2:0] dr,
                        input logic ld, input logic isld);
    hz.id_valid    = v;
    hz.id_SR1      = sr1;
    hz.id_sr1_used = u1;
    hz.id_SR2      = sr2;
    hz.id_sr2_used = u2;
    hz.id_DR       = dr;
    hz.id_load_reg = ld;
    hz.id_is_load  = isld;
  endtask

  task automatic chk_stall(input string tag, input logic lus, input logic sid, input logic bex);
    chk({tag, ".load_use_stall"}, 32'(hz.load_use_stall), 32'(lus));
    chk({tag, ".stall_id"},       32'(hz.stall_id),       32'(sid));
    chk({tag, ".bubble_ex"},      32'(hz.bubble_ex),      32'(bex));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    hz.mem_stall  = 1'b0;
    hz.flush      = 1'b0;
    hz.stat_clear = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Reset state
    chk_stall("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.ex_mem_DR",       32'(hz.ex_mem_DR),       32'd0);
    chk("rst.mem_wb_DR",       32'(hz.mem_wb_DR),       32'd0);
    chk("rst.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd0);
    chk("rst.mem_wb_load_reg", 32'(hz.mem_wb_load_reg), 32'd0);
    chk("rst.pending_mask",    32'(hz.pending_mask),    32'd0);
    chk("rst.stall_count",     32'(hz.stall_count),     32'd0);

    // LDR R3 then dependent ADD R4 <- R3: one bubble
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    #1 chk_stall("ldr3", 1'b0, 1'b0, 1'b0);
    tick();
    chk("ldr3.pending", 32'(hz.pending_mask), 32'h08);
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    #1 chk_stall("use3", 1'b1, 1'b1, 1'b1);
    tick();
    #1;
    chk("use3.stall_count",     32'(hz.stall_count),     32'd1);
    chk("use3.after_stall",     32'(hz.load_use_stall),  32'd0);
    chk("use3.ex_mem_DR",       32'(hz.ex_mem_DR),       32'd3);
    chk("use3.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd1);
    chk("use3.pending",         32'(hz.pending_mask),    32'h08);
    tick();
    chk("add4.mem_wb_DR",       32'(hz.mem_wb_DR),       32'd3);
    chk("add4.mem_wb_load_reg", 32'(hz.mem_wb_load_reg), 32'd1);
    chk("add4.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd0);
    chk("add4.pending",         32'(hz.pending_mask),    32'h18);

    // ADD R2 then ADD R6 <- R2: forwarded, no stall
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    #1 chk_stall("add2", 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0);
    #1 chk_stall("use2", 1'b0, 1'b0, 1'b0);
    tick();
    chk("add2.ex_mem_DR",       32'(hz.ex_mem_DR),       32'd2);
    chk("add2.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd1);
    chk("add2.mem_wb_DR",       32'(hz.mem_wb_DR),       32'd4);
    hz.id_valid = 1'b0;
    tick();
    chk("add2.wb_DR",           32'(hz.mem_wb_DR),       32'd2);
    chk("add2.wb_load_reg",     32'(hz.mem_wb_load_reg), 32'd1);
    chk("add2.ex_mem_DR6",      32'(hz.ex_mem_DR),       32'd6);
    chk("add2.pending",         32'(hz.pending_mask),    32'h44);

    // LDR R5 then dependent under a 3-cycle memory freeze
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0);
    hz.mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_stall("frz", 1'b1, 1'b1, 1'b0);
      tick();
      chk("frz.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd0);
      chk("frz.mem_wb_DR",       32'(hz.mem_wb_DR),       32'd6);
      chk("frz.pending",         32'(hz.pending_mask),    32'h60);
      chk("frz.stall_count",     32'(hz.stall_count),     32'd1);
    end
    hz.mem_stall = 1'b0;
    #1 chk_stall("frz.release", 1'b1, 1'b1, 1'b1);
    tick();
    chk("frz.stall_count2",    32'(hz.stall_count),     32'd2);
    chk("frz.after_stall",     32'(hz.load_use_stall),  32'd0);
    chk("frz.ex_mem_DR",       32'(hz.ex_mem_DR),       32'd5);
    chk("frz.ex_mem_load_reg", 32'(hz.ex_mem_load_reg), 32'd1);

    // Drain the shadow pipeline
    hz.id_valid = 1'b0;
    repeat (3) tick();
    chk("drain.pending", 32'(hz.pending_mask), 32'h00);

    // LDR R1 then dependent with flush: flush wins
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    hz.flush = 1'b1;
    #1 chk_stall("flush", 1'b0, 1'b0, 1'b0);
    tick();
    hz.flush    = 1'b0;
    hz.id_valid = 1'b0;
    #1;
    chk("flush.pending",     32'(hz.pending_mask), 32'h02);
    chk("flush.ex_mem_DR",   32'(hz.ex_mem_DR),    32'd1);
    chk("flush.stall_count", 32'(hz.stall_count),  32'd2);

    // LDR R3 <- [R3] held in ID: hazard every other cycle
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    #1 chk_stall("sat.first", 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("sat.bubble_on", 32'(hz.bubble_ex), 32'd1);
      tick();
      chk("sat.bubble_off", 32'(hz.bubble_ex), 32'd0);
      tick();
      if (i == 11) chk("sat.max_minus_1", 32'(hz.stall_count), 32'd14);
    end
    chk("sat.saturated", 32'(hz.stall_count), 32'd15);
    hz.stat_clear = 1'b1;
    #1 chk("clr.bubble", 32'(hz.bubble_ex), 32'd1);
    tick();
    hz.stat_clear = 1'b0;
    #1;
    chk("clr.stall_count", 32'(hz.stall_count), 32'd0);
    chk("clr.bubble_off",  32'(hz.bubble_ex),   32'd0);
    tick();

    // Reset in the middle of a hazard cycle
    chk("rst2.hazard", 32'(hz.load_use_stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_stall("rst2", 1'b0, 1'b0, 1'b0);
    chk("rst2.pending",     32'(hz.pending_mask), 32'h00);
    chk("rst2.stall_count", 32'(hz.stall_count),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

Tracks the destination registers of the instructions in flight in EX, MEM and WB using a shadow pipeline of the LC-3b datapath. Detects load-use hazards against the instruction in ID and generates the stall and bubble controls for the IF/ID and ID/EX latches. Drives the EX/MEM and MEM/WB destination and write-enable information that the operand forwarding logic compares against. Sits beside the ID stage and advances in lockstep with the pipeline latches.

## Interface
- STALL_CNT_WIDTH, 16, width of the saturating load-use stall counter
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_SR1, id_SR2  in  lc3b_reg  ID source register numbers
- id_sr1_used, id_sr2_used  in  1  the corresponding source is actually read
- id_DR  in  lc3b_reg  ID destination register
- id_load_reg  in  1  ID instruction writes id_DR
- id_is_load  in  1  ID instruction is LDR/LDB/LDI (data available only after MEM)
- mem_stall  in  1  MEM is waiting on memory; the whole pipeline freezes
- flush  in  1  taken branch or trap; the ID instruction is discarded
- stat_clear  in  1  clears stall_count
- load_use_stall  out  1  load-use hazard on the ID instruction
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX on this edge
- ex_mem_DR, mem_wb_DR  out  lc3b_reg  shadow MEM and WB destinations
- ex_mem_load_reg, mem_wb_load_reg  out  1  shadow MEM and WB entries are valid and write their DR
- pending_mask  out  8  bit r is set when any valid shadow entry writes register r
- stall_count  out  STALL_CNT_WIDTH  number of cycles in which a load-use bubble was inserted

## Operation
- State: three shadow entries EX, MEM and WB. Each entry holds {valid, dr, load_reg, is_load}. Plus stall_count.
- Hazard, combinational:
  - load_use_stall = id_valid & !flush & EX.valid & EX.load_reg & EX.is_load & ((id_sr1_used & id_SR1==EX.dr) | (id_sr2_used & id_SR2==EX.dr)).
- Controls:
  - stall_id = load_use_stall | mem_stall.
  - bubble_ex = load_use_stall & !mem_stall.
- Sources matching MEM or WB entries produce no stall; forwarding resolves them.
- Shadow update on each edge:
  - mem_stall=1: all entries hold. This has priority over flush and the hazard.
  - Else, if load_use_stall or flush or !id_valid: EX <= bubble (valid=0). MEM <= EX. WB <= MEM.
  - Else: EX <= {1, id_DR, id_load_reg, id_is_load}. MEM <= EX. WB <= MEM.
- Shadow outputs:
  - ex_mem_DR = MEM.dr; ex_mem_load_reg = MEM.valid & MEM.load_reg.
  - mem_wb_DR = WB.dr; mem_wb_load_reg = WB.valid & WB.load_reg.
- pending_mask is the OR over entries with valid & load_reg of the one-hot decode of dr.
- stall_count:
  - Increments by 1 on each edge where bubble_ex=1.
  - Saturates at all-ones; it does not wrap.
  - stat_clear has priority over the increment.
- reset:
  - All entries are cleared to valid=0, dr=0, load_reg=0, is_load=0, and stall_count=0.
  - Therefore every output is 0 after reset.
  - Reset mid-stall drops the hazard on the next cycle.

## Timing
- Hazard outputs are combinational from the current state and the ID inputs, with zero-cycle latency; they are valid before the same edge.
- A load in EX followed by a dependent instruction in ID gives exactly one bubble cycle. On the next cycle the load sits in MEM and the stall deasserts.
- If mem_stall rises while load_use_stall=1, bubble_ex drops while stall_id stays high. The hazard re-evaluates after the freeze, and the bubble is inserted on the first non-frozen edge.
- Under a simultaneous flush and hazard, flush wins: no stall, and a bubble enters EX.
- The shadow MEM and WB outputs change only on edges where mem_stall=0.
- A register in both MEM and WB is reported in both; forwarding priority is the consumer's concern.

## Structure
- lc3b_types gains the shadow entry struct typedef (valid, dr, load_reg, is_load) and a constant for the bubble entry value.
- One sub-module: hazard_shadow_stage, a single shadow entry register with hold, bubble and load controls. It is instantiated three times.
- The hazard compare, the mask decode and the counter live in the top module.

## Test plan
- After reset: all outputs are 0. Issue LDR R3 with id_is_load=1, then next cycle ADD with SR1=R3 and sr1_used=1 -> load_use_stall=1, bubble_ex=1, stall_count=1. The following cycle has the stall at 0, and ex_mem_DR=3 with ex_mem_load_reg=1.
- ADD R2 followed by ADD using R2 (not a load) -> no stall. Next cycle ex_mem_DR=2 and ex_mem_load_reg=1. One cycle later mem_wb_DR=2 and mem_wb_load_reg=1.
- Load R5, then a dependent instruction with mem_stall=1 for 3 cycles -> stall_id=1 and bubble_ex=0 throughout, with entries held. On release: one bubble, and stall_count increments once.
- Load R1, then a dependent instruction with flush=1 in the same cycle -> load_use_stall=0. Next cycle EX.valid=0 and pending_mask=8'b0000_0010.
- Preload stall_count to all-ones minus 1 with repeated hazards. After two more hazards stall_count stays all-ones. Pulse stat_clear together with a hazard -> stall_count=0.
- Assert reset during a hazard cycle -> next cycle pending_mask=0 and all stall outputs are 0.
